// File: rtl/pkg_mikro.sv
// Shared types and constants for the paged-memory block-copy engine.
package pkg_mikro;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } dma_stan_t;

  // The top address of every page holds the page-select register.
  localparam logic [7:0] ADR_STRONA = 8'd255;

endpackage

// File: rtl/dma_sprawdz_zakres.sv
// Checks that a block of len bytes starting at base stays below the page register.
module dma_sprawdz_zakres #(
  parameter int unsigned AW = 8,
  parameter int unsigned LW = 8
) (
  input  logic [AW-1:0] base_i,
  input  logic [LW-1:0] len_i,
  output logic          ok_o
);

  localparam int unsigned SW = AW + 1;
  localparam logic [SW-1:0] OSTATNI = SW'((2 ** AW) - 2);

  logic [SW-1:0] koniec;

  // One extra bit so a block running past the page wraps into a large value, not a small one.
  always_comb begin
    koniec = SW'(base_i) + SW'(len_i) - SW'(1);
    ok_o   = (koniec <= OSTATNI);
  end

endmodule

// File: rtl/kopiarka_pamieci_dma.sv
// Block-copy engine in front of the paged data memory; passes CPU accesses through when idle.
module kopiarka_pamieci_dma
  import pkg_mikro::*;
#(
  parameter int unsigned ADDR_WIDTH_MEM = $bits(ADR_STRONA),
  parameter int unsigned DATA_WIDTH_MEM = 8,
  parameter int unsigned LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_wr_mem,
  input  logic [ADDR_WIDTH_MEM-1:0] cpu_adres,
  input  logic [DATA_WIDTH_MEM-1:0] cpu_dane,
  output logic [DATA_WIDTH_MEM-1:0] cpu_out,
  output logic                      cpu_stall,
  input  logic                      start,
  input  logic [ADDR_WIDTH_MEM-1:0] src_adres,
  input  logic [ADDR_WIDTH_MEM-1:0] dst_adres,
  input  logic [LEN_WIDTH-1:0]      dlugosc,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      mem_wr,
  output logic [ADDR_WIDTH_MEM-1:0] mem_adres,
  output logic [DATA_WIDTH_MEM-1:0] mem_dane,
  input  logic [DATA_WIDTH_MEM-1:0] mem_out
);

  localparam int unsigned AW = ADDR_WIDTH_MEM;
  localparam int unsigned DW = DATA_WIDTH_MEM;
  localparam int unsigned LW = LEN_WIDTH;

  dma_stan_t     stan_q, stan_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, idx_nast;
  logic [DW-1:0] buf_q, buf_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, stall_q, stall_d;
  logic          src_ok, dst_ok;

  dma_sprawdz_zakres #(.AW(AW), .LW(LW)) u_zakres_src (
    .base_i (src_adres),
    .len_i  (dlugosc),
    .ok_o   (src_ok)
  );

  dma_sprawdz_zakres #(.AW(AW), .LW(LW)) u_zakres_dst (
    .base_i (dst_adres),
    .len_i  (dlugosc),
    .ok_o   (dst_ok)
  );

  assign idx_nast = idx_q + LW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stan_q  <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      stan_q  <= stan_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  // Memory port is combinational so IDLE pass-through stays zero-latency for the CPU.
  always_comb begin
    stan_d    = stan_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mem_wr    = 1'b0;
    mem_adres = cpu_adres;
    mem_dane  = cpu_dane;
    cpu_out   = '0;

    case (stan_q)
      IDLE: begin
        mem_wr  = cpu_wr_mem;
        cpu_out = mem_out;
        if (start) begin
          if (dlugosc == '0) begin
            done_d = 1'b1;
          end else if (src_ok && dst_ok) begin
            src_d  = src_adres;
            dst_d  = dst_adres;
            len_d  = dlugosc;
            idx_d  = '0;
            stan_d = RD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD: begin
        mem_adres = src_q + AW'(idx_q);
        mem_dane  = buf_q;
        buf_d     = mem_out;
        stan_d    = WR;
      end
      WR: begin
        mem_adres = dst_q + AW'(idx_q);
        mem_dane  = buf_q;
        mem_wr    = 1'b1;
        idx_d     = idx_nast;
        if (idx_nast == len_q) begin
          stan_d = DONE;
          done_d = 1'b1;
        end else begin
          stan_d = RD;
        end
      end
      DONE: begin
        stan_d = IDLE;
      end
      default: begin
        stan_d = IDLE;
      end
    endcase

    busy_d  = (stan_d == RD) || (stan_d == WR);
    stall_d = (stan_d != IDLE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_stall = stall_q;

endmodule

// File: tb/tb_kopiarka_pamieci_dma.sv
// Scoreboard bench for the block-copy engine with a paged memory model behind it.
module tb_kopiarka_pamieci_dma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_wr_mem = 1'b0;
  logic [7:0] cpu_adres = 8'h33;
  logic [7:0] cpu_dane = 8'h5C;
  logic [7:0] cpu_out;
  logic       cpu_stall;
  logic       start = 1'b0;
  logic [7:0] src_adres = 8'h00;
  logic [7:0] dst_adres = 8'h00;
  logic [7:0] dlugosc = 8'h00;
  logic       busy, done, err;
  logic       mem_wr;
  logic [7:0] mem_adres, mem_dane, mem_out;

  kopiarka_pamieci_dma #(
    .ADDR_WIDTH_MEM (8),
    .DATA_WIDTH_MEM (8),
    .LEN_WIDTH      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_wr_mem (cpu_wr_mem),
    .cpu_adres  (cpu_adres),
    .cpu_dane   (cpu_dane),
    .cpu_out    (cpu_out),
    .cpu_stall  (cpu_stall),
    .start      (start),
    .src_adres  (src_adres),
    .dst_adres  (dst_adres),
    .dlugosc    (dlugosc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_wr     (mem_wr),
    .mem_adres  (mem_adres),
    .mem_dane   (mem_dane),
    .mem_out    (mem_out)
  );

  always #5 clk = ~clk;

  // Paged memory: address 255 is the page register, other addresses hit the selected page.
  logic [7:0] pamiec [0:1023];
  logic [7:0] strona = 8'd0;

  assign mem_out = (mem_adres == 8'd255) ? strona : pamiec[{strona[1:0], mem_adres}];

  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_adres == 8'd255) strona <= mem_dane;
      else pamiec[{strona[1:0], mem_adres}] <= mem_dane;
    end
  end

  typedef struct packed {
    logic [1:0] k;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  ev_t oczek[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string nazwa, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nazwa, got, want, $time);
    end
  endtask

  function automatic void oczekuj(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.k = k;
    e.a = a;
    e.d = d;
    oczek.push_back(e);
  endfunction

  task automatic zglos(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
    ev_t obs;
    ev_t e;
    obs.k = k;
    obs.a = a;
    obs.d = d;
    if (oczek.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: unexpected event got=%0h want=none (t=%0t)", obs, $time);
    end else begin
      e = oczek.pop_front();
      chk("scoreboard", 32'(obs), 32'(e));
    end
  endtask

  // Monitor: every memory write, done pulse and err pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_wr) zglos(K_WR, mem_adres, mem_dane);
      if (done) zglos(K_DONE, 8'h00, 8'h00);
      if (err) zglos(K_ERR, 8'h00, 8'h00);
    end
  end

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    oczekuj(K_WR, a, d);
    cpu_wr_mem = 1'b1;
    cpu_adres  = a;
    cpu_dane   = d;
    @(posedge clk); #1;
    cpu_wr_mem = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [7:0] want);
    @(posedge clk); #1;
    cpu_wr_mem = 1'b0;
    cpu_adres  = a;
    @(negedge clk);
    chk($sformatf("cpu_read[%0d]", a), 32'(cpu_out), 32'(want));
  endtask

  // Issue one request and measure done/err cycle and busy length relative to the start edge.
  task automatic zadanie(input string nazwa, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input int want_done, input int want_busy,
                         input int want_err);
    int done_c = 0;
    int err_c = 0;
    int busy_n = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    src_adres = s;
    dst_adres = d;
    dlugosc   = n;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2 * int'(n) + 4; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done && done_c == 0) done_c = c;
      if (err && err_c == 0) err_c = c;
    end
    chk({nazwa, " done_cycle"}, 32'(done_c), 32'(want_done));
    chk({nazwa, " busy_cycles"}, 32'(busy_n), 32'(want_busy));
    chk({nazwa, " err_cycle"}, 32'(err_c), 32'(want_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_n;

    // Reset state and IDLE pass-through
    #3;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst mem_wr", 32'(mem_wr), 32'd0);
    chk("rst mem_adres", 32'(mem_adres), 32'h33);
    chk("rst mem_dane", 32'(mem_dane), 32'h5C);
    #9;
    rst_n = 1'b1;

    // 1: plain copy 10..13 -> 100..103
    cpu_write(8'd10, 8'hA1);
    cpu_write(8'd11, 8'hA2);
    cpu_write(8'd12, 8'hA3);
    cpu_write(8'd13, 8'hA4);
    oczekuj(K_WR, 8'd100, 8'hA1);
    oczekuj(K_WR, 8'd101, 8'hA2);
    oczekuj(K_WR, 8'd102, 8'hA3);
    oczekuj(K_WR, 8'd103, 8'hA4);
    oczekuj(K_DONE, 8'h00, 8'h00);
    zadanie("copy4", 8'd10, 8'd100, 8'd4, 9, 8, 0);
    cpu_read(8'd100, 8'hA1);
    cpu_read(8'd103, 8'hA4);

    // 2: no-op, rejected range, and the last legal byte
    oczekuj(K_DONE, 8'h00, 8'h00);
    zadanie("len0", 8'd10, 8'd100, 8'd0, 1, 0, 0);
    oczekuj(K_ERR, 8'h00, 8'h00);
    zadanie("src250", 8'd250, 8'd10, 8'd6, 0, 0, 1);
    oczekuj(K_ERR, 8'h00, 8'h00);
    zadanie("dst255", 8'd10, 8'd255, 8'd1, 0, 0, 1);
    oczekuj(K_WR, 8'd254, 8'hA1);
    oczekuj(K_DONE, 8'h00, 8'h00);
    zadanie("dst254", 8'd10, 8'd254, 8'd1, 3, 2, 0);
    chk("page reg after 254", 32'(strona), 32'd0);

    // 3: CPU hammers addr 20 during a copy
    cpu_write(8'd20, 8'h00);
    oczekuj(K_WR, 8'd20, 8'h55);
    oczekuj(K_WR, 8'd30, 8'hA1);
    oczekuj(K_WR, 8'd31, 8'hA2);
    oczekuj(K_DONE, 8'h00, 8'h00);
    oczekuj(K_WR, 8'd20, 8'h55);
    @(posedge clk); #1;
    cpu_wr_mem = 1'b1;
    cpu_adres  = 8'd20;
    cpu_dane   = 8'h55;
    start      = 1'b1;
    src_adres  = 8'd10;
    dst_adres  = 8'd30;
    dlugosc    = 8'd2;
    @(negedge clk);
    chk("stall cycle0", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    start   = 1'b0;
    stall_n = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (cpu_stall) stall_n++;
      if (c == 1) chk("cpu_out while stalled", 32'(cpu_out), 32'd0);
    end
    chk("stall cycles", 32'(stall_n), 32'd5);
    @(negedge clk);
    chk("stall after done", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    cpu_wr_mem = 1'b0;
    cpu_read(8'd20, 8'h55);

    // 4: overlapping ascending copy
    cpu_write(8'd0, 8'h11);
    cpu_write(8'd1, 8'h22);
    cpu_write(8'd2, 8'h33);
    cpu_write(8'd3, 8'h44);
    oczekuj(K_WR, 8'd1, 8'h11);
    oczekuj(K_WR, 8'd2, 8'h11);
    oczekuj(K_WR, 8'd3, 8'h11);
    oczekuj(K_DONE, 8'h00, 8'h00);
    zadanie("overlap", 8'd0, 8'd1, 8'd3, 7, 6, 0);
    cpu_read(8'd3, 8'h11);

    // 5: reset during the third write of an 8-byte copy
    for (int i = 0; i < 8; i++) cpu_write(8'(i), 8'(i + 1));
    cpu_write(8'd202, 8'hEE);
    oczekuj(K_WR, 8'd200, 8'h01);
    oczekuj(K_WR, 8'd201, 8'h02);
    @(posedge clk); #1;
    start     = 1'b1;
    src_adres = 8'd0;
    dst_adres = 8'd200;
    dlugosc   = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("3rd WR mem_wr", 32'(mem_wr), 32'd1);
    chk("3rd WR mem_adres", 32'(mem_adres), 32'd202);
    chk("3rd WR mem_dane", 32'(mem_dane), 32'h03);
    rst_n = 1'b0;
    #1;
    chk("rst mid mem_wr", 32'(mem_wr), 32'd0);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid cpu_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mem[200]", 32'(pamiec[200]), 32'h01);
    chk("mem[201]", 32'(pamiec[201]), 32'h02);
    chk("mem[202] untouched", 32'(pamiec[202]), 32'hEE);
    cpu_read(8'd202, 8'hEE);

    // 6: copy inside page 3
    cpu_write(8'd50, 8'h5A);
    cpu_write(8'd51, 8'h5B);
    cpu_write(8'd255, 8'h03);
    cpu_write(8'd0, 8'hC1);
    cpu_write(8'd1, 8'hC2);
    cpu_write(8'd50, 8'h00);
    cpu_write(8'd51, 8'h00);
    oczekuj(K_WR, 8'd50, 8'hC1);
    oczekuj(K_WR, 8'd51, 8'hC2);
    oczekuj(K_DONE, 8'h00, 8'h00);
    zadanie("page3", 8'd0, 8'd50, 8'd2, 5, 4, 0);
    chk("p3 mem[50]", 32'(pamiec[3*256+50]), 32'hC1);
    chk("p3 mem[51]", 32'(pamiec[3*256+51]), 32'hC2);
    chk("p0 mem[50]", 32'(pamiec[50]), 32'h5A);
    chk("p0 mem[51]", 32'(pamiec[51]), 32'h5B);
    cpu_read(8'd255, 8'h03);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(oczek.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
